spi_req_arbiter: RTL and testbench
==================================

Name: spi_req_arbiter

Overview:
Round-robin arbiter and sequencer that shares one spi_master between NUM_REQ independent requesters.
- Picks one pending requester and latches its transmit word.
- Drives spi_master's spi_enable/tx_datain, tracks its busy handshake, captures rx_dataout and returns it with a one-cycle done pulse.
- Sits between the SPI master and the register/DMA clients.

Parameters:
NUM_REQ, 4, number of requesters (>=1)
DATA_WIDTH, 8, SPI word width; must match spi_master DATA_WIDTH
TIMEOUT_CYCLES, 1024, watchdog limit in clk cycles (used only with SPI_ARB_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req  in  NUM_REQ  per-requester transfer request, level
req_data  in  NUM_REQ*DATA_WIDTH  flattened tx words; requester i at [i*DATA_WIDTH +: DATA_WIDTH]
grant  out  NUM_REQ  one-hot owner of current transfer; 0 when idle
done  out  NUM_REQ  one-cycle completion pulse to owner
rx_data  out  DATA_WIDTH  received word; valid in the done cycle, held until next done
spi_enable  out  1  to spi_master spi_enable
spi_tx_data  out  DATA_WIDTH  to spi_master tx_datain
spi_busy  in  1  from spi_master busy
spi_rx_data  in  DATA_WIDTH  from spi_master rx_dataout
arb_busy  out  1  high from grant through the done cycle
timeout_err  out  1  one-cycle pulse with done on watchdog abort; tied 0 without macro

Behaviour:
- Reset (sync, rst=1 at posedge):
  - grant, done, rx_data, spi_enable, spi_tx_data, arb_busy, timeout_err = 0.
  - state = IDLE; round-robin pointer = 0, so requester 0 has top priority.
- States and transitions: IDLE, LAUNCH, WAIT_DONE, COMPLETE.
- IDLE:
  - If |req and spi_busy==0: pick winner, register grant one-hot, spi_tx_data <= winner's req_data, spi_enable <= 1, arb_busy <= 1, go to LAUNCH.
  - If spi_busy==1, stay in IDLE; never launch onto a busy master.
- LAUNCH:
  - Hold spi_enable=1 until spi_busy==1 is sampled.
  - Then spi_enable <= 0 and go to WAIT_DONE.
  - Holding enable until busy rises tolerates the master's IDLE->START latency.
- WAIT_DONE:
  - On spi_busy==0: rx_data <= spi_rx_data (master updates rx_dataout and drops busy on the same edge).
  - Same cycle: done[owner] <= 1, go to COMPLETE.
- COMPLETE (one cycle):
  - done <= 0, grant <= 0, arb_busy <= 0, pointer <= owner+1 (mod NUM_REQ), go to IDLE.
  - Guarantees the master has returned to IDLE with cs high before the next launch.
- Latency: req high in IDLE -> grant and spi_enable 1 cycle later.
- Arbitration:
  - Search starts at pointer and wraps modulo NUM_REQ; lowest index at or after pointer wins.
  - A requester that just finished can win again only if no other req is set.
  - NUM_REQ=1 degenerates to pass-through.
- Requester rules:
  - req_data is sampled only at grant.
  - Dropping req after grant does not abort; the transfer completes and done still pulses.
  - Requester must deassert req in the done cycle or be eligible again.
- Simultaneous events: changes to req while arb_busy=1 are ignored until the return to IDLE.
- Reset mid-transfer: all outputs return to reset values next cycle, with no done pulse. spi_master is reset by the same rst.

Optional Feature:
Macro: SPI_ARB_TIMEOUT_EN.
- Defined:
  - Counter clears on entering LAUNCH and increments every cycle in LAUNCH/WAIT_DONE.
  - On reaching TIMEOUT_CYCLES-1 without completion: spi_enable <= 0, done[owner] and timeout_err pulse together, rx_data <= 0, go to COMPLETE.
- Not defined: no counter logic; timeout_err constant 0; the arbiter waits indefinitely.

Decomposition:
- Shared package spi_pkg: state encoding constants (IDLE=0, LAUNCH=1, WAIT_DONE=2, COMPLETE=3), default DATA_WIDTH, default NUM_REQ.
- Sub-module spi_rr_pick: combinational round-robin picker; inputs req and pointer, outputs one-hot winner and winner index.

Test Plan:
- Single req[2]=1, req_data[2]=8'hA5, slave returns 8'h3C -> grant=4'b0100 one cycle later; spi_tx_data=A5; done[2] pulses once; rx_data=3C; arb_busy low after COMPLETE.
- req=4'b1111 held continuously, pointer at reset -> grants in order 0,1,2,3,0, each with a distinct tx word on MOSI.
- req[1] dropped one cycle after grant -> transfer completes; done[1] still pulses; no grant to 1 afterwards.
- spi_busy forced high in IDLE with req[0]=1 -> no spi_enable until spi_busy falls, then normal launch.
- rst pulsed mid-WAIT_DONE -> next cycle all outputs 0, pointer 0, no done pulse; new req[3] served normally afterwards.
- SPI_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=16, spi_busy stuck low after launch -> at cycle 16 done and timeout_err pulse together; rx_data=0; arbiter back in IDLE.

Source files
------------

// File: rtl/spi_pkg.sv
// -----------------------------------------------------------------------------
// spi_pkg
// Shared definitions for the SPI request arbiter slice:
//   - arb_state_e : arbiter FSM state encoding (IDLE=0, LAUNCH=1,
//                   WAIT_DONE=2, COMPLETE=3)
//   - DEF_DATA_WIDTH / DEF_NUM_REQ : default word width and requester count
//   - idx_width() : width of an index into NUM_REQ requesters (min 1 bit)
// -----------------------------------------------------------------------------
package spi_pkg;

    localparam int DEF_DATA_WIDTH = 8;
    localparam int DEF_NUM_REQ    = 4;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_LAUNCH    = 2'd1,
        ST_WAIT_DONE = 2'd2,
        ST_COMPLETE  = 2'd3
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/spi_rr_pick.sv
// -----------------------------------------------------------------------------
// spi_rr_pick
// Combinational round-robin picker. Starting at ptr_i and wrapping modulo
// NUM_REQ, the first asserted request wins.
// Ports:
//   req_i     in  NUM_REQ  pending requests
//   ptr_i     in  IDX_W    highest-priority index for this pick
//   winner_o  out NUM_REQ  one-hot winner (0 when no request)
//   win_idx_o out IDX_W    binary index of the winner (0 when no request)
// -----------------------------------------------------------------------------
module spi_rr_pick
    import spi_pkg::*;
#(
    parameter  int NUM_REQ = DEF_NUM_REQ,
    localparam int IDX_W   = idx_width(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDX_W-1:0]   ptr_i,
    output logic [NUM_REQ-1:0] winner_o,
    output logic [IDX_W-1:0]   win_idx_o
);

    logic             found;
    logic [IDX_W-1:0] cand;

    always_comb begin
        winner_o  = '0;
        win_idx_o = '0;
        found     = 1'b0;
        cand      = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand = IDX_W'((int'(ptr_i) + k) % NUM_REQ);
            if (!found && req_i[cand]) begin
                found           = 1'b1;
                winner_o[cand]  = 1'b1;
                win_idx_o       = cand;
            end
        end
    end

endmodule

// File: rtl/spi_req_arbiter.sv
// -----------------------------------------------------------------------------
// spi_req_arbiter
// Round-robin arbiter/sequencer sharing one spi_master between NUM_REQ
// requesters. Latches the winner's tx word, launches the master, waits for
// its busy handshake, captures the received word and pulses done to the owner.
//
// Optional feature: define SPI_ARB_TIMEOUT_EN to enable a watchdog that aborts
// a transfer after TIMEOUT_CYCLES cycles in LAUNCH/WAIT_DONE (done and
// timeout_err pulse together, rx_data cleared). Without it timeout_err is 0.
//
// Ports:
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   req          in   per-requester level request
//   req_data     in   flattened tx words, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   grant        out  one-hot owner of current transfer, 0 when idle
//   done         out  one-cycle completion pulse to owner
//   rx_data      out  received word, valid in done cycle, held until next done
//   spi_enable   out  to spi_master spi_enable
//   spi_tx_data  out  to spi_master tx_datain
//   spi_busy     in   from spi_master busy
//   spi_rx_data  in   from spi_master rx_dataout
//   arb_busy     out  high from grant through the done cycle
//   timeout_err  out  watchdog abort pulse (with done)
// -----------------------------------------------------------------------------
module spi_req_arbiter
    import spi_pkg::*;
#(
    parameter int NUM_REQ        = DEF_NUM_REQ,
    parameter int DATA_WIDTH     = DEF_DATA_WIDTH,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            grant,
    output logic [NUM_REQ-1:0]            done,
    output logic [DATA_WIDTH-1:0]         rx_data,
    output logic                          spi_enable,
    output logic [DATA_WIDTH-1:0]         spi_tx_data,
    input  logic                          spi_busy,
    input  logic [DATA_WIDTH-1:0]         spi_rx_data,
    output logic                          arb_busy,
    output logic                          timeout_err
);

    localparam int IDX_W = idx_width(NUM_REQ);

    arb_state_e            state_q, state_d;
    logic [NUM_REQ-1:0]    grant_q, grant_d;
    logic [NUM_REQ-1:0]    done_q, done_d;
    logic [DATA_WIDTH-1:0] rx_q, rx_d;
    logic                  en_q, en_d;
    logic [DATA_WIDTH-1:0] txd_q, txd_d;
    logic                  abusy_q, abusy_d;
    logic [IDX_W-1:0]      ptr_q, ptr_d;
    logic [IDX_W-1:0]      owner_q, owner_d;

    logic [NUM_REQ-1:0]    win_oh;
    logic [IDX_W-1:0]      win_idx;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             tmo_q, tmo_d;
    logic             tmo_hit;
    assign tmo_hit = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`endif

    spi_rr_pick #(
        .NUM_REQ   (NUM_REQ)
    ) u_pick (
        .req_i     (req),
        .ptr_i     (ptr_q),
        .winner_o  (win_oh),
        .win_idx_o (win_idx)
    );

    always_comb begin
        state_d = state_q;
        grant_d = grant_q;
        done_d  = '0;
        rx_d    = rx_q;
        en_d    = en_q;
        txd_d   = txd_q;
        abusy_d = abusy_q;
        ptr_d   = ptr_q;
        owner_d = owner_q;

        case (state_q)
            ST_IDLE: begin
                // Never launch onto a master that is still busy.
                if (|req && !spi_busy) begin
                    grant_d = win_oh;
                    owner_d = win_idx;
                    txd_d   = req_data[int'(win_idx)*DATA_WIDTH +: DATA_WIDTH];
                    en_d    = 1'b1;
                    abusy_d = 1'b1;
                    state_d = ST_LAUNCH;
                end
            end
            ST_LAUNCH: begin
                // Enable is held until busy is seen, covering the master's
                // IDLE->START latency.
                if (spi_busy) begin
                    en_d    = 1'b0;
                    state_d = ST_WAIT_DONE;
                end
            end
            ST_WAIT_DONE: begin
                // Master updates rx_dataout on the same edge busy falls.
                if (!spi_busy) begin
                    rx_d    = spi_rx_data;
                    done_d  = grant_q;
                    state_d = ST_COMPLETE;
                end
            end
            ST_COMPLETE: begin
                // One idle cycle lets the master return to IDLE (cs high)
                // before any new launch.
                grant_d = '0;
                abusy_d = 1'b0;
                ptr_d   = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + IDX_W'(1);
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

`ifdef SPI_ARB_TIMEOUT_EN
        tmo_d = 1'b0;
        cnt_d = '0;
        if (state_q == ST_LAUNCH || state_q == ST_WAIT_DONE) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        // Abort only when the normal progress condition is not met this cycle.
        if (tmo_hit && ((state_q == ST_LAUNCH && !spi_busy) ||
                        (state_q == ST_WAIT_DONE && spi_busy))) begin
            en_d    = 1'b0;
            done_d  = grant_q;
            tmo_d   = 1'b1;
            rx_d    = '0;
            state_d = ST_COMPLETE;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            done_q  <= '0;
            rx_q    <= '0;
            en_q    <= 1'b0;
            txd_q   <= '0;
            abusy_q <= 1'b0;
            ptr_q   <= '0;
            owner_q <= '0;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
            done_q  <= done_d;
            rx_q    <= rx_d;
            en_q    <= en_d;
            txd_q   <= txd_d;
            abusy_q <= abusy_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
`ifdef SPI_ARB_TIMEOUT_EN
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
`endif
        end
    end

    assign grant       = grant_q;
    assign done        = done_q;
    assign rx_data     = rx_q;
    assign spi_enable  = en_q;
    assign spi_tx_data = txd_q;
    assign arb_busy    = abusy_q;
`ifdef SPI_ARB_TIMEOUT_EN
    assign timeout_err = tmo_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_req_arbiter.sv
// -----------------------------------------------------------------------------
// tb_spi_req_arbiter
// Scoreboard bench: stimulus pushes expected launches/completions into queues,
// monitor processes pop and compare when grant rises or done pulses.
// A small behavioural spi_master answers rx = tx ^ m_xor.
// -----------------------------------------------------------------------------
module tb_spi_req_arbiter;

    localparam int NR  = 4;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NR-1:0]     req = '0;
    logic [NR*DW-1:0]  req_data;
    logic [NR-1:0]     grant, done;
    logic [DW-1:0]     rx_data, spi_tx_data, spi_rx_data;
    logic              spi_enable, spi_busy, arb_busy, timeout_err;

    // Master model controls and state
    logic              force_busy = 1'b0;
    logic              m_stuck    = 1'b0;
    logic [DW-1:0]     m_xor      = 8'hFF;
    logic              m_busy, m_lat;
    logic [3:0]        m_cnt;
    logic [DW-1:0]     m_tx, m_rx;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [NR-1:0] oh;
        logic [DW-1:0] d;
        logic          tmo;
    } exp_t;

    exp_t launch_q[$];
    exp_t done_q[$];

    spi_req_arbiter #(
        .NUM_REQ        (NR),
        .DATA_WIDTH     (DW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .req_data    (req_data),
        .grant       (grant),
        .done        (done),
        .rx_data     (rx_data),
        .spi_enable  (spi_enable),
        .spi_tx_data (spi_tx_data),
        .spi_busy    (spi_busy),
        .spi_rx_data (spi_rx_data),
        .arb_busy    (arb_busy),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    assign spi_busy    = m_busy | force_busy;
    assign spi_rx_data = m_rx;

    // Behavioural master: one cycle start latency, 4 busy cycles, rx and
    // busy-fall on the same edge.
    always @(posedge clk) begin
        if (rst) begin
            m_busy <= 1'b0;
            m_lat  <= 1'b0;
            m_cnt  <= '0;
            m_rx   <= '0;
            m_tx   <= '0;
        end else if (m_busy) begin
            if (m_cnt == 0) begin
                m_busy <= 1'b0;
                m_rx   <= m_tx ^ m_xor;
            end else begin
                m_cnt <= m_cnt - 4'd1;
            end
        end else if (m_lat) begin
            m_lat  <= 1'b0;
            m_busy <= 1'b1;
            m_cnt  <= 4'd3;
        end else if (spi_enable && !force_busy && !m_stuck) begin
            m_lat <= 1'b1;
            m_tx  <= spi_tx_data;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic push_launch(input logic [NR-1:0] oh, input logic [DW-1:0] d);
        exp_t e;
        e.oh = oh; e.d = d; e.tmo = 1'b0;
        launch_q.push_back(e);
    endtask

    task automatic push_done(input logic [NR-1:0] oh, input logic [DW-1:0] d, input logic tmo);
        exp_t e;
        e.oh = oh; e.d = d; e.tmo = tmo;
        done_q.push_back(e);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_grant(output int n);
        n = 0;
        while (grant == '0 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("wait_grant", 32'(grant != '0), 32'd1);
    endtask

    task automatic wait_done(output int n);
        n = 0;
        while (done == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("wait_done", 32'(done != '0), 32'd1);
    endtask

    // Launch monitor: compares owner and tx word when grant rises.
    initial begin
        logic [NR-1:0] prev_grant;
        exp_t          e;
        prev_grant = '0;
        forever begin
            @(negedge clk);
            if (grant != '0 && prev_grant == '0) begin
                if (launch_q.size() == 0) begin
                    chk("unexpected_grant", 32'(grant), 32'd0);
                end else begin
                    e = launch_q.pop_front();
                    chk("grant", 32'(grant), 32'(e.oh));
                    chk("spi_tx_data", 32'(spi_tx_data), 32'(e.d));
                    chk("spi_enable_at_grant", 32'(spi_enable), 32'd1);
                end
            end
            prev_grant = grant;
        end
    end

    // Completion monitor: compares done, rx_data and timeout_err.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (done != '0) begin
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = done_q.pop_front();
                    chk("done", 32'(done), 32'(e.oh));
                    chk("rx_data", 32'(rx_data), 32'(e.d));
                    chk("timeout_err", 32'(timeout_err), 32'(e.tmo));
                    chk("arb_busy_in_done", 32'(arb_busy), 32'd1);
                end
            end else if (timeout_err != 1'b0) begin
                chk("stray_timeout_err", 32'(timeout_err), 32'd0);
            end
        end
    end

    task automatic chk_all_zero(input string tag);
        chk({tag, "_grant"},       32'(grant),       32'd0);
        chk({tag, "_done"},        32'(done),        32'd0);
        chk({tag, "_rx_data"},     32'(rx_data),     32'd0);
        chk({tag, "_spi_enable"},  32'(spi_enable),  32'd0);
        chk({tag, "_spi_tx_data"}, 32'(spi_tx_data), 32'd0);
        chk({tag, "_arb_busy"},    32'(arb_busy),    32'd0);
        chk({tag, "_timeout_err"}, 32'(timeout_err), 32'd0);
    endtask

    initial begin
        int  n;
        int  cnt;
        logic seen;
        req_data = {8'h44, 8'h33, 8'h22, 8'h11};

        // Reset state
        rst = 1'b1;
        tick(3);
        chk_all_zero("reset");
        rst = 1'b0;
        tick(1);

        // Round robin from reset pointer: 0,1,2,3,0
        push_launch(4'b0001, 8'h11); push_done(4'b0001, 8'hEE, 1'b0);
        push_launch(4'b0010, 8'h22); push_done(4'b0010, 8'hDD, 1'b0);
        push_launch(4'b0100, 8'h33); push_done(4'b0100, 8'hCC, 1'b0);
        push_launch(4'b1000, 8'h44); push_done(4'b1000, 8'hBB, 1'b0);
        push_launch(4'b0001, 8'h11); push_done(4'b0001, 8'hEE, 1'b0);
        req = 4'b1111;
        for (int i = 0; i < 5; i++) begin
            wait_done(n);
            if (i == 4) req = '0;
            tick(1);
        end
        chk("rr_idle_after", 32'(arb_busy), 32'd0);

        // Single requester 2: tx A5, slave returns 3C
        m_xor = 8'h99;
        req_data[23:16] = 8'hA5;
        push_launch(4'b0100, 8'hA5); push_done(4'b0100, 8'h3C, 1'b0);
        req = 4'b0100;
        tick(1);
        chk("single_grant_latency", 32'(grant), 32'h4);
        wait_done(n);
        req = '0;
        tick(1);
        chk("single_arb_busy_after", 32'(arb_busy), 32'd0);
        chk("single_grant_after", 32'(grant), 32'd0);
        chk("single_rx_held", 32'(rx_data), 32'h3C);
        req_data[23:16] = 8'h33;
        m_xor = 8'hFF;

        // Requester 1 drops req one cycle after grant
        push_launch(4'b0010, 8'h22); push_done(4'b0010, 8'hDD, 1'b0);
        req = 4'b0010;
        wait_grant(n);
        tick(1);
        req = '0;
        wait_done(n);
        tick(10);
        chk("drop_no_regrant", 32'(grant), 32'd0);

        // Busy master in IDLE blocks the launch
        force_busy = 1'b1;
        req = 4'b0001;
        seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick(1);
            if (spi_enable || grant != '0) seen = 1'b1;
        end
        chk("busy_blocks_launch", 32'(seen), 32'd0);
        push_launch(4'b0001, 8'h11); push_done(4'b0001, 8'hEE, 1'b0);
        force_busy = 1'b0;
        wait_done(n);
        req = '0;
        tick(1);

        // Reset in WAIT_DONE: no done, outputs cleared, pointer back to 0
        push_launch(4'b0010, 8'h22);
        req = 4'b0010;
        wait_grant(n);
        cnt = 0;
        while (!(spi_busy && !spi_enable) && cnt < 50) begin
            tick(1);
            cnt++;
        end
        chk("reached_wait_done", 32'(spi_busy && !spi_enable), 32'd1);
        tick(1);
        req = '0;
        rst = 1'b1;
        tick(1);
        chk_all_zero("midreset");
        rst = 1'b0;
        tick(10);
        push_launch(4'b0001, 8'h11); push_done(4'b0001, 8'hEE, 1'b0);
        push_launch(4'b1000, 8'h44); push_done(4'b1000, 8'hBB, 1'b0);
        req = 4'b1001;
        wait_done(n);
        req = 4'b1000;
        tick(1);
        wait_done(n);
        req = '0;
        tick(1);

`ifdef SPI_ARB_TIMEOUT_EN
        // Master never answers: watchdog aborts after TMO cycles
        m_stuck = 1'b1;
        push_launch(4'b0100, 8'h33); push_done(4'b0100, 8'h00, 1'b1);
        req = 4'b0100;
        wait_grant(n);
        wait_done(n);
        chk("timeout_latency", 32'(n), 32'(TMO));
        chk("timeout_enable_low", 32'(spi_enable), 32'd0);
        req = '0;
        tick(1);
        chk("timeout_back_idle", 32'(arb_busy), 32'd0);
        m_stuck = 1'b0;
`endif

        tick(5);
        chk("launch_q_drained", 32'(launch_q.size()), 32'd0);
        chk("done_q_drained", 32'(done_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
